// File: rtl/mem_port_arbiter.sv
// Arbiter for the unified memory port shared by instruction fetch and load/store.
// Serialises accesses, latches the memory payload and counts the fixed memory latency.
module mem_port_arbiter #(
  parameter int MEM_LATENCY     = 4,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [0:3][7:0]  d_wdata,
  output logic [0:3][7:0]  d_rdata,
  output logic             d_ack,
  output logic [31:0]      mem_addr,
  output logic [0:3][7:0]  mem_data_in,
  output logic             mem_write_en,
  input  logic [0:3][7:0]  mem_data_out,
  output logic             busy,
  output logic             owner
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] streak;
  logic       we_q;

  logic sample;
  logic grant_d;
  logic grant_f;

  // The closing edge of RESP samples requests like IDLE does, so a requester
  // that keeps req high with a fresh payload is served at one access per L+1 cycles.
  always_comb begin
    sample  = (state == ST_IDLE) || (state == ST_RESP);
    grant_d = d_req && (!if_req || (streak != STREAK_MAX));
    grant_f = if_req && !grant_d;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      streak      <= 4'd0;
      we_q        <= 1'b0;
      owner       <= 1'b0;
      mem_addr    <= 32'd0;
      mem_data_in <= '0;
      if_rdata    <= 32'd0;
      d_rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (sample && grant_d) begin
            state       <= ST_ACCESS;
            cnt         <= 4'd0;
            owner       <= 1'b1;
            mem_addr    <= d_addr;
            we_q        <= d_we;
            mem_data_in <= d_we ? d_wdata : '0;
            if (if_req)
              streak <= (streak == STREAK_MAX) ? STREAK_MAX : streak + 4'd1;
            else
              streak <= 4'd0;
          end else if (sample && grant_f) begin
            state       <= ST_ACCESS;
            cnt         <= 4'd0;
            owner       <= 1'b0;
            mem_addr    <= if_addr;
            we_q        <= 1'b0;
            mem_data_in <= '0;
            streak      <= 4'd0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAT_LAST) begin
            state <= ST_RESP;
            if (!we_q) begin
              if (owner) d_rdata  <= mem_data_out;
              else       if_rdata <= mem_data_out;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from registered state so an asynchronous reset drops them at once.
  always_comb begin
    busy         = (state != ST_IDLE);
    if_ack       = (state == ST_RESP) && !owner;
    d_ack        = (state == ST_RESP) && owner;
    mem_write_en = (state == ST_ACCESS) && we_q;
  end

endmodule
